jhash_core: RTL and testbench

//  Jenkins lookup3 (hashword) engine. Consumes the 3x32-bit block stream from jhash_in.

---
 rtl/jhash_core_if.sv | 47 ++++
 rtl/jhash_core.sv | 171 +++++++++++++++++
 tb/tb_jhash_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jhash_core_if.sv
// jhash_core_if: groups the block-stream input and the hash-result output of jhash_core.
//   Latency: none; this is wiring only.
//   Backpressure: stream_ack acknowledges blocks; hash_valid is held until hash_ack.
// Ports carried: hash_init, hash_len, stream_data0..2, stream_valid, stream_left,
//   stream_done, stream_ack, hash_out, hash_valid, hash_ack, and hash_out2 when
//   JHASH_CORE_HASH2_EN is defined.
interface jhash_core_if;
  logic [31:0] hash_init;
  logic [31:0] hash_len;
  logic [31:0] stream_data0;
  logic [31:0] stream_data1;
  logic [31:0] stream_data2;
  logic        stream_valid;
  logic [1:0]  stream_left;
  logic        stream_done;
  logic        stream_ack;
  logic [31:0] hash_out;
  logic        hash_valid;
  logic        hash_ack;
`ifdef JHASH_CORE_HASH2_EN
  logic [31:0] hash_out2;

  modport slave (
    input  hash_init, hash_len, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_left, stream_done, hash_ack,
    output stream_ack, hash_out, hash_valid, hash_out2
  );

  modport master (
    output hash_init, hash_len, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_left, stream_done, hash_ack,
    input  stream_ack, hash_out, hash_valid, hash_out2
  );
`else
  modport slave (
    input  hash_init, hash_len, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_left, stream_done, hash_ack,
    output stream_ack, hash_out, hash_valid
  );

  modport master (
    output hash_init, hash_len, stream_data0, stream_data1, stream_data2,
           stream_valid, stream_left, stream_done, hash_ack,
    input  stream_ack, hash_out, hash_valid
  );
`endif
endinterface

// File: rtl/jhash_core.sv
// jhash_core: Jenkins lookup3 hashword engine, one mix()/final() line per cycle.
//   Latency: 6 cycles per absorbed block; done seen in WAIT -> hash_valid 8 cycles later.
//   Backpressure: stream_ack only in IDLE/WAIT (<= 1 accept per 7 cycles); hash_valid held until hash_ack.
// Ports: clk, rst (async, active-high), jif (jhash_core_if.slave: block stream in, hash out).
// Option: define JHASH_CORE_HASH2_EN to expose b as hash_out2 (hashword2 pb result).
module jhash_core #(
  parameter logic [31:0] GOLDEN = 32'hdeadbeef
) (
  input  logic         clk,
  input  logic         rst,
  jhash_core_if.slave  jif
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MIX, S_FINAL, S_OUT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] a_q, b_q, c_q;
  logic [31:0] a_d, b_d, c_d;
  logic [31:0] pend0_q, pend1_q, pend2_q;
  logic [31:0] pend0_d, pend1_d, pend2_d;
  logic [1:0]  pend_left_q, pend_left_d;
  logic [31:0] init_val;
  logic [31:0] ta, tb, tc;

  function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

  assign init_val = GOLDEN + (jif.hash_len << 2) + jif.hash_init;

  // The most recent block is held in pend until we know whether it is the last
  // one: a following block means it gets mix(), done means it gets final().
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    pend2_d     = pend2_q;
    pend_left_d = pend_left_q;
    ta          = a_q;
    tb          = b_q;
    tc          = c_q;

    case (state_q)
      S_IDLE: begin
        if (jif.stream_valid) begin
          a_d         = init_val;
          b_d         = init_val;
          c_d         = init_val;
          pend0_d     = jif.stream_data0;
          pend1_d     = jif.stream_data1;
          pend2_d     = jif.stream_data2;
          pend_left_d = jif.stream_left;
          state_d     = S_WAIT;
        end else if (jif.stream_done) begin
          // Empty message: result is the initial value, final() is skipped.
          a_d     = init_val;
          b_d     = init_val;
          c_d     = init_val;
          state_d = S_OUT;
        end
      end

      S_WAIT: begin
        if (jif.stream_valid) begin
          a_d         = a_q + pend0_q;
          b_d         = b_q + pend1_q;
          c_d         = c_q + pend2_q;
          pend0_d     = jif.stream_data0;
          pend1_d     = jif.stream_data1;
          pend2_d     = jif.stream_data2;
          pend_left_d = jif.stream_left;
          step_d      = 3'd0;
          state_d     = S_MIX;
        end else if (jif.stream_done) begin
          // pend_left 0 encodes a full block of 3 words.
          a_d = a_q + pend0_q;
          if (pend_left_q != 2'd1) b_d = b_q + pend1_q;
          if (pend_left_q == 2'd0) c_d = c_q + pend2_q;
          step_d  = 3'd0;
          state_d = S_FINAL;
        end
      end

      S_MIX: begin
        // Within each line the third op's source is untouched by the first two,
        // so every term can be taken straight from the registers.
        case (step_q)
          3'd0: begin ta = (a_q - c_q) ^ rot(c_q, 4);  tc = c_q + b_q; end
          3'd1: begin tb = (b_q - a_q) ^ rot(a_q, 6);  ta = a_q + c_q; end
          3'd2: begin tc = (c_q - b_q) ^ rot(b_q, 8);  tb = b_q + a_q; end
          3'd3: begin ta = (a_q - c_q) ^ rot(c_q, 16); tc = c_q + b_q; end
          3'd4: begin tb = (b_q - a_q) ^ rot(a_q, 19); ta = a_q + c_q; end
          default: begin tc = (c_q - b_q) ^ rot(b_q, 4); tb = b_q + a_q; end
        endcase
        a_d = ta;
        b_d = tb;
        c_d = tc;
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = S_WAIT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      S_FINAL: begin
        case (step_q)
          3'd0: tc = (c_q ^ b_q) - rot(b_q, 14);
          3'd1: ta = (a_q ^ c_q) - rot(c_q, 11);
          3'd2: tb = (b_q ^ a_q) - rot(a_q, 25);
          3'd3: tc = (c_q ^ b_q) - rot(b_q, 16);
          3'd4: ta = (a_q ^ c_q) - rot(c_q, 4);
          3'd5: tb = (b_q ^ a_q) - rot(a_q, 14);
          default: tc = (c_q ^ b_q) - rot(b_q, 24);
        endcase
        a_d = ta;
        b_d = tb;
        c_d = tc;
        if (step_q == 3'd6) begin
          step_d  = 3'd0;
          state_d = S_OUT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      S_OUT: begin
        if (jif.hash_ack) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      c_q         <= 32'd0;
      pend0_q     <= 32'd0;
      pend1_q     <= 32'd0;
      pend2_q     <= 32'd0;
      pend_left_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      pend2_q     <= pend2_d;
      pend_left_q <= pend_left_d;
    end
  end

  assign jif.stream_ack = jif.stream_valid & ((state_q == S_IDLE) | (state_q == S_WAIT));
  assign jif.hash_valid = (state_q == S_OUT);
  assign jif.hash_out   = c_q;
`ifdef JHASH_CORE_HASH2_EN
  assign jif.hash_out2  = b_q;
`endif

endmodule

// File: tb/tb_jhash_core.sv
// tb_jhash_core: randomized self-checking bench for jhash_core against a lookup3 hashword model.
//   Latency: checks 1-cycle empty result and 8-cycle done-to-hash latency.
//   Backpressure: holds hash_ack low and presents blocks during OUT.
module tb_jhash_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jhash_core_if jif ();

  jhash_core #(.GOLDEN(32'hdeadbeef)) dut (
    .clk (clk),
    .rst (rst),
    .jif (jif)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] msg [0:63];
  int          acc_cyc [$];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Reference: C hashword()/hashword2() over msg[0..n-1].
  task automatic ref_hash(input int n, input logic [31:0] init,
                          output logic [31:0] rc, output logic [31:0] rb);
    logic [31:0] a, b, c;
    int len, i;
    a = 32'hdeadbeef + (32'(n) << 2) + init;
    b = a;
    c = a;
    len = n;
    i = 0;
    while (len > 3) begin
      a += msg[i]; b += msg[i+1]; c += msg[i+2];
      a -= c; a ^= rotl(c, 4);  c += b;
      b -= a; b ^= rotl(a, 6);  a += c;
      c -= b; c ^= rotl(b, 8);  b += a;
      a -= c; a ^= rotl(c, 16); c += b;
      b -= a; b ^= rotl(a, 19); a += c;
      c -= b; c ^= rotl(b, 4);  b += a;
      len -= 3;
      i += 3;
    end
    if (len > 0) begin
      if (len == 3) c += msg[i+2];
      if (len >= 2) b += msg[i+1];
      a += msg[i];
      c ^= b; c -= rotl(b, 14);
      a ^= c; a -= rotl(c, 11);
      b ^= a; b -= rotl(a, 25);
      c ^= b; c -= rotl(b, 16);
      a ^= c; a -= rotl(c, 4);
      b ^= a; b -= rotl(a, 14);
      c ^= b; c -= rotl(b, 24);
    end
    rc = c;
    rb = b;
  endtask

  task automatic fill_msg(input int n);
    for (int i = 0; i < n; i++) msg[i] = $urandom;
  endtask

  task automatic put_block(input int idx, input int nleft, input bit with_done, output bit ok);
    jif.stream_data0 = msg[idx];
    jif.stream_data1 = (nleft >= 2) ? msg[idx+1] : $urandom;
    jif.stream_data2 = (nleft == 3) ? msg[idx+2] : $urandom;
    jif.stream_left  = (nleft == 3) ? 2'd0 : 2'(nleft);
    jif.stream_valid = 1'b1;
    if (with_done) jif.stream_done = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (jif.stream_ack) begin
        ok = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    jif.stream_valid = 1'b0;
    jif.stream_data0 = $urandom;
    jif.stream_data1 = $urandom;
    jif.stream_data2 = $urandom;
  endtask

  // Called just after a posedge; returns at a negedge with hash_valid high (if ok).
  task automatic start_msg(input int n, input logic [31:0] init, input bit early_done,
                           output bit ok, output int lat);
    int nb, nleft, t0;
    bit okb, okh;
    ok  = 1'b1;
    lat = -1;
    t0  = cyc;
    jif.hash_init = init;
    jif.hash_len  = 32'(n);
    if (n == 0) begin
      jif.stream_done = 1'b1;
      t0 = cyc;
    end else begin
      nb = (n + 2) / 3;
      for (int bi = 0; bi < nb; bi++) begin
        nleft = (n - 3*bi >= 3) ? 3 : n - 3*bi;
        put_block(3*bi, nleft, early_done && (bi == nb-1), okb);
        if (!okb) ok = 1'b0;
        if (bi == 0) begin
          jif.hash_init = $urandom;
          jif.hash_len  = $urandom;
        end
      end
      if (!early_done) jif.stream_done = 1'b1;
      t0 = cyc;
    end
    okh = 1'b0;
    for (int i = 0; i < 200 && !okh; i++) begin
      @(negedge clk);
      if (jif.hash_valid) begin
        okh = 1'b1;
        lat = cyc - t0;
      end
    end
    if (!okh) ok = 1'b0;
    jif.stream_done = 1'b0;
  endtask

  // Called at a negedge; returns just after a posedge in IDLE.
  task automatic take_hash(output logic hv_after);
    jif.hash_ack = 1'b1;
    @(posedge clk);
    #1;
    jif.hash_ack = 1'b0;
    @(negedge clk);
    hv_after = jif.hash_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (jif.hash_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hash_valid: got %b expected 0", jif.hash_valid);
    end
    n_chk++;
    if (jif.stream_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_stream_ack: got %b expected 0", jif.stream_ack);
    end
    n_chk++;
    if (jif.hash_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_hash_out: got %h expected 00000000", jif.hash_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty();
    bit ok; int lat; logic hv;
    start_msg(0, 32'd0, 1'b0, ok, lat);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL empty_timeout: got no hash_valid expected hash_valid"); end
    n_chk++;
    if (lat !== 1) begin n_fail++; $display("FAIL empty_latency: got %0d expected 1", lat); end
    n_chk++;
    if (jif.hash_out !== 32'hdeadbeef) begin
      n_fail++; $display("FAIL empty_hash: got %h expected deadbeef", jif.hash_out);
    end
    take_hash(hv);
    n_chk++;
    if (hv !== 1'b0) begin n_fail++; $display("FAIL empty_valid_drop: got %b expected 0", hv); end
  endtask

  task automatic test_single();
    bit ok; int lat; logic hv; logic [31:0] ec, eb;
    msg[0] = 32'd1; msg[1] = 32'd2; msg[2] = 32'd3;
    ref_hash(3, 32'd0, ec, eb);
    start_msg(3, 32'd0, 1'b0, ok, lat);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: got no hash_valid expected hash_valid"); end
    n_chk++;
    if (lat !== 8) begin n_fail++; $display("FAIL single_latency: got %0d expected 8", lat); end
    n_chk++;
    if (jif.hash_out !== ec) begin
      n_fail++; $display("FAIL single_hash: got %h expected %h", jif.hash_out, ec);
    end
`ifdef JHASH_CORE_HASH2_EN
    n_chk++;
    if (jif.hash_out2 !== eb) begin
      n_fail++; $display("FAIL single_hash2: got %h expected %h", jif.hash_out2, eb);
    end
`endif
    take_hash(hv);
    n_chk++;
    if (hv !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", hv); end
  endtask

  task automatic test_multi_block();
    bit ok; int lat; logic hv; logic [31:0] ec, eb;
    fill_msg(7);
    ref_hash(7, 32'h12345678, ec, eb);
    acc_cyc.delete();
    start_msg(7, 32'h12345678, 1'b0, ok, lat);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL multi_timeout: got no hash_valid expected hash_valid"); end
    n_chk++;
    if (acc_cyc.size() != 3) begin
      n_fail++; $display("FAIL multi_accepts: got %0d expected 3", acc_cyc.size());
    end else if (acc_cyc[2] - acc_cyc[1] < 7) begin
      n_fail++; $display("FAIL multi_spacing: got %0d expected >=7", acc_cyc[2] - acc_cyc[1]);
    end
    n_chk++;
    if (jif.hash_out !== ec) begin
      n_fail++; $display("FAIL multi_hash: got %h expected %h", jif.hash_out, ec);
    end
    take_hash(hv);
  endtask

  task automatic test_valid_with_done();
    bit ok; int lat; logic hv; logic [31:0] ec, eb, init;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 0) ? 6 : (k == 1) ? 8 : 3;
      init = $urandom;
      fill_msg(n);
      ref_hash(n, init, ec, eb);
      start_msg(n, init, 1'b1, ok, lat);
      n_chk++;
      if (!ok || jif.hash_out !== ec) begin
        n_fail++; $display("FAIL valid_done_hash n=%0d: got %h expected %h", n, jif.hash_out, ec);
      end
      take_hash(hv);
    end
  endtask

  task automatic test_hold_output();
    bit ok; int lat; logic hv; logic [31:0] ec, eb, init;
    init = $urandom;
    fill_msg(4);
    ref_hash(4, init, ec, eb);
    start_msg(4, init, 1'b0, ok, lat);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL hold_timeout: got no hash_valid expected hash_valid"); end
    jif.stream_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (jif.hash_valid !== 1'b1 || jif.hash_out !== ec) begin
        n_fail++;
        $display("FAIL hold_stable cyc%0d: got valid=%b hash=%h expected valid=1 hash=%h",
                 i, jif.hash_valid, jif.hash_out, ec);
      end
      n_chk++;
      if (jif.stream_ack !== 1'b0) begin
        n_fail++; $display("FAIL hold_no_ack cyc%0d: got %b expected 0", i, jif.stream_ack);
      end
    end
    jif.stream_valid = 1'b0;
    take_hash(hv);
    n_chk++;
    if (hv !== 1'b0) begin n_fail++; $display("FAIL hold_valid_drop: got %b expected 0", hv); end
  endtask

  task automatic test_reset_mid_mix();
    bit ok, okb; int lat; logic hv; logic [31:0] ec, eb, init;
    fill_msg(9);
    jif.hash_init = $urandom;
    jif.hash_len  = 32'd9;
    put_block(0, 3, 1'b0, okb);
    put_block(3, 3, 1'b0, okb);
    @(posedge clk);
    #3;
    jif.stream_valid = 1'b1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (jif.hash_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", jif.hash_valid);
    end
    n_chk++;
    if (jif.stream_ack !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_idle: got stream_ack %b expected 1", jif.stream_ack);
    end
    @(negedge clk);
    jif.stream_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    init = $urandom;
    fill_msg(5);
    ref_hash(5, init, ec, eb);
    start_msg(5, init, 1'b0, ok, lat);
    n_chk++;
    if (!ok || jif.hash_out !== ec) begin
      n_fail++; $display("FAIL rst_mid_next_hash: got %h expected %h", jif.hash_out, ec);
    end
`ifdef JHASH_CORE_HASH2_EN
    n_chk++;
    if (jif.hash_out2 !== eb) begin
      n_fail++; $display("FAIL rst_mid_next_hash2: got %h expected %h", jif.hash_out2, eb);
    end
`endif
    take_hash(hv);
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; logic hv; logic [31:0] ec, eb, init;
    int n, d;
    bit early;
    for (int k = 0; k < 10; k++) begin
      n     = $urandom_range(0, 14);
      init  = $urandom;
      early = 1'($urandom_range(0, 1));
      d     = $urandom_range(0, 3);
      fill_msg(n);
      ref_hash(n, init, ec, eb);
      start_msg(n, init, early, ok, lat);
      for (int i = 0; i < d; i++) @(negedge clk);
      n_chk++;
      if (!ok || jif.hash_out !== ec) begin
        n_fail++; $display("FAIL b2b_hash n=%0d: got %h expected %h", n, jif.hash_out, ec);
      end
`ifdef JHASH_CORE_HASH2_EN
      n_chk++;
      if (jif.hash_out2 !== eb) begin
        n_fail++; $display("FAIL b2b_hash2 n=%0d: got %h expected %h", n, jif.hash_out2, eb);
      end
`endif
      take_hash(hv);
    end
  endtask

  initial begin
    jif.hash_init    = 32'd0;
    jif.hash_len     = 32'd0;
    jif.stream_data0 = 32'd0;
    jif.stream_data1 = 32'd0;
    jif.stream_data2 = 32'd0;
    jif.stream_valid = 1'b0;
    jif.stream_left  = 2'd0;
    jif.stream_done  = 1'b0;
    jif.hash_ack     = 1'b0;
    test_reset();
    test_empty();
    test_single();
    test_multi_block();
    test_valid_with_done();
    test_hold_output();
    test_reset_mid_mix();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
